// File: rtl/uc_sequencer.sv
// uc_sequencer: fetch/execute sequencer for the 4-bit microprocessor.
// Holds the PC, the fetch register (instr/oprnd), the C/Z flags and the phase flop.
// It forms the microcode ROM address and applies the returned control word to its own state.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset_n    in   1   asynchronous active-low reset
//   enable     in   1   global advance enable
//   prog_byte  in   8   program memory data at pc ({opcode, operand/jump-high})
//   ctrl_word  in  13   microcode word: [12] incPC, [11] loadPC, [9] loadFlags
//   alu_c      in   1   ALU carry
//   alu_z      in   1   ALU zero
//   step       in   1   single-step request (only when UC_SINGLE_STEP_EN is defined)
//   rom_addr   out  7   {instr, flag_c, flag_z, phase}
//   pc         out 12   program counter
//   instr      out  4   fetched opcode
//   oprnd      out  4   fetched operand
//   phase      out  1   0 = fetch, 1 = execute
//   flag_c     out  1   registered carry flag
//   flag_z     out  1   registered zero flag
//
// Optional feature: define UC_SINGLE_STEP_EN to add the step input. A fetch then only
// proceeds on a detected rising edge of step, so each pulse runs exactly one instruction.

module uc_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [7:0]  prog_byte,
    input  logic [12:0] ctrl_word,
    input  logic        alu_c,
    input  logic        alu_z,
`ifdef UC_SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic [6:0]  rom_addr,
    output logic [11:0] pc,
    output logic [3:0]  instr,
    output logic [3:0]  oprnd,
    output logic        phase,
    output logic        flag_c,
    output logic        flag_z
);

    localparam logic PhFetch = 1'b0;
    localparam logic PhExec  = 1'b1;

    logic [11:0] pc_q, pc_d;
    logic [3:0]  instr_q, instr_d;
    logic [3:0]  oprnd_q, oprnd_d;
    logic        phase_q, phase_d;
    logic        flag_c_q, flag_c_d;
    logic        flag_z_q, flag_z_d;

    logic [12:0] ctrl_eff;
    logic        inc_pc;
    logic        load_pc;
    logic        load_flags;
    logic        advance;

    // The ROM's default word may contain X/Z; such a word must act as a no-op.
    // In synthesis the word is always known, so this reduces to a plain wire.
    always_comb begin
        ctrl_eff = ctrl_word;
        if ((^ctrl_word) === 1'bx) begin
            ctrl_eff = '0;
        end
    end

    assign inc_pc     = ctrl_eff[12];
    assign load_pc    = ctrl_eff[11];
    assign load_flags = ctrl_eff[9];

    // Datapath-owned fields, deliberately ignored here.
    logic unused_ctrl;
    assign unused_ctrl = ^{ctrl_eff[10], ctrl_eff[8:0]};

`ifdef UC_SINGLE_STEP_EN
    logic step_q;
    logic step_rise;

    // Detector runs regardless of enable so a held step never re-triggers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign step_rise = step & ~step_q;
    // Execute always completes; a fetch waits for a step edge.
    assign advance   = enable & ((phase_q == PhExec) | step_rise);
`else
    assign advance   = enable;
`endif

    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        oprnd_d  = oprnd_q;
        phase_d  = phase_q;
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;

        if (advance) begin
            phase_d = ~phase_q;

            if (phase_q == PhFetch) begin
                instr_d = prog_byte[7:4];
                oprnd_d = prog_byte[3:0];
            end

            // Load takes priority over increment.
            if (load_pc) begin
                pc_d = {oprnd_q, prog_byte};
            end else if (inc_pc) begin
                pc_d = pc_q + 12'd1;
            end

            if (load_flags) begin
                flag_c_d = alu_c;
                flag_z_d = alu_z;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q     <= 12'h000;
            instr_q  <= 4'h0;
            oprnd_q  <= 4'h0;
            phase_q  <= PhFetch;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            oprnd_q  <= oprnd_d;
            phase_q  <= phase_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
        end
    end

    assign rom_addr = {instr_q, flag_c_q, flag_z_q, phase_q};
    assign pc       = pc_q;
    assign instr    = instr_q;
    assign oprnd    = oprnd_q;
    assign phase    = phase_q;
    assign flag_c   = flag_c_q;
    assign flag_z   = flag_z_q;

endmodule

// File: tb/tb_uc_sequencer.sv
// tb_uc_sequencer: directed self-checking bench for uc_sequencer.
// Build with UC_SINGLE_STEP_EN defined to also cover single-step operation.

module tb_uc_sequencer;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [7:0]  prog_byte;
    logic [12:0] ctrl_word;
    logic        alu_c;
    logic        alu_z;
    logic [6:0]  rom_addr;
    logic [11:0] pc;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic        phase;
    logic        flag_c;
    logic        flag_z;
`ifdef UC_SINGLE_STEP_EN
    logic        step;
    logic        auto_step;
`endif

    int errors;
    int checks;

    uc_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .prog_byte (prog_byte),
        .ctrl_word (ctrl_word),
        .alu_c     (alu_c),
        .alu_z     (alu_z),
`ifdef UC_SINGLE_STEP_EN
        .step      (step),
`endif
        .rom_addr  (rom_addr),
        .pc        (pc),
        .instr     (instr),
        .oprnd     (oprnd),
        .phase     (phase),
        .flag_c    (flag_c),
        .flag_z    (flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One rising edge; returns 1 time unit after it, away from the edge.
    task automatic tick();
`ifdef UC_SINGLE_STEP_EN
        // In the common sequence, request a step for every fetch so behaviour
        // matches the free-running build.
        if (auto_step) step = ~phase;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [11:0] e_pc, input logic [3:0] e_in,
                               input logic [3:0] e_op, input logic e_ph, input logic e_c,
                               input logic e_z);
        check({tag, ".pc"}, 16'(pc), 16'(e_pc));
        check({tag, ".instr"}, 16'(instr), 16'(e_in));
        check({tag, ".oprnd"}, 16'(oprnd), 16'(e_op));
        check({tag, ".phase"}, 16'(phase), 16'(e_ph));
        check({tag, ".flags"}, 16'({flag_c, flag_z}), 16'({e_c, e_z}));
        check({tag, ".rom_addr"}, 16'(rom_addr), 16'({e_in, e_c, e_z, e_ph}));
    endtask

    int toggles;
    logic prev_phase;

    initial begin
        errors    = 0;
        checks    = 0;
        reset_n   = 1'b0;
        enable    = 1'b1;
        prog_byte = 8'h5A;
        ctrl_word = 13'h1008;
        alu_c     = 1'b0;
        alu_z     = 1'b0;
`ifdef UC_SINGLE_STEP_EN
        step      = 1'b0;
        auto_step = 1'b1;
`endif
        // Reset held across edges
        tick();
        tick();
        check_state("reset", 12'h000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Release between edges; first edge is a fetch
        reset_n = 1'b1;
        tick();
        check_state("first_fetch", 12'h001, 4'h5, 4'hA, 1'b1, 1'b0, 1'b0);
        check("first_fetch.rom_addr_lit", 16'(rom_addr), 16'(7'b0101001));

        // Jump taken: fetch 0x33 then execute with loadPC, target byte 0xC4
        ctrl_word = 13'h0000;
        tick();
        prog_byte = 8'h33;
        tick();
        check_state("jmp_fetch", 12'h001, 4'h3, 4'h3, 1'b1, 1'b0, 1'b0);
        prog_byte = 8'hC4;
        ctrl_word = 13'h0808;
        tick();
        check_state("jmp", 12'h3C4, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0);

        // Load + increment together: load wins
        prog_byte = 8'h33;
        ctrl_word = 13'h0000;
        tick();
        prog_byte = 8'hC4;
        ctrl_word = 13'h1808;
        tick();
        check_state("jmp_prio", 12'h3C4, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0);

        // Flag load in execute
        prog_byte = 8'h70;
        ctrl_word = 13'h0000;
        alu_c     = 1'b1;
        alu_z     = 1'b0;
        tick();
        ctrl_word = 13'h0682;
        tick();
        check_state("flag_load", 12'h3C4, 4'h7, 4'h0, 1'b0, 1'b1, 1'b0);
        check("flag_load.rom_addr21", 16'(rom_addr[2:1]), 16'(2'b10));

        // Next instruction without loadFlags: flags hold despite new ALU values
        alu_c     = 1'b0;
        alu_z     = 1'b1;
        ctrl_word = 13'h1008;
        tick();
        tick();
        check_state("flag_hold", 12'h3C6, 4'h7, 4'h0, 1'b0, 1'b1, 1'b0);

        // Jump to 0xFFF, then increment wraps to 0x000
        prog_byte = 8'hFF;
        ctrl_word = 13'h0000;
        tick();
        ctrl_word = 13'h0808;
        tick();
        check_state("to_fff", 12'hFFF, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
        ctrl_word = 13'h1008;
        tick();
        check_state("wrap", 12'h000, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0);

        // Hold with enable low, even with every control bit asserted
        enable    = 1'b0;
        prog_byte = 8'h12;
        ctrl_word = 13'h1A08;
        alu_c     = 1'b0;
        alu_z     = 1'b1;
        tick();
        tick();
        tick();
        check_state("hold", 12'h000, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0);
        enable = 1'b1;

        // Reach execute phase at pc = 0x2A7
        ctrl_word = 13'h0000;
        tick();
        prog_byte = 8'h22;
        tick();
        prog_byte = 8'hA7;
        ctrl_word = 13'h0808;
        tick();
        prog_byte = 8'h55;
        ctrl_word = 13'h0000;
        tick();
        check_state("mid_exec", 12'h2A7, 4'h5, 4'h5, 1'b1, 1'b1, 1'b0);

        // Async reset between edges
        #2;
        reset_n = 1'b0;
        #1;
        check_state("async_rst", 12'h000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;

`ifdef UC_SINGLE_STEP_EN
        // Single-step: no step for 10 cycles means no progress
        auto_step = 1'b0;
        step      = 1'b0;
        ctrl_word = 13'h1008;
        prog_byte = 8'h5A;
        for (int i = 0; i < 10; i++) tick();
        check("ss_idle.phase", 16'(phase), 16'd0);
        check("ss_idle.pc", 16'(pc), 16'h000);

        // One 1-cycle pulse: exactly two phase toggles, pc + 2
        toggles    = 0;
        prev_phase = phase;
        step = 1'b1;
        tick();
        step = 1'b0;
        if (phase != prev_phase) toggles++;
        prev_phase = phase;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (phase != prev_phase) toggles++;
            prev_phase = phase;
        end
        check("ss_pulse.toggles", 16'(toggles), 16'd2);
        check("ss_pulse.pc", 16'(pc), 16'h002);
        check("ss_pulse.phase", 16'(phase), 16'd0);

        // Step held high for 8 cycles: only one instruction
        step = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("ss_held.pc", 16'(pc), 16'h004);
        check("ss_held.phase", 16'(phase), 16'd0);
        step = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
